tx_sync_fifo: RTL
=================

# tx_sync_fifo

Single-clock, parametrised transmit FIFO with inferred storage, selectable first-word-fall-through (FWFT) or standard read mode, and threshold flags. It reports occupancy, sticky overflow/underflow errors and supports a synchronous flush. It replaces the async controller-plus-RAM pairing on TX paths where producer and consumer share one clock.

## Interface
- DATA_WIDTH, 8, word width in bits
- PTR_WIDTH, 11, address width; DEPTH = 2**PTR_WIDTH words
- FWFT, 1, read mode: 1 = head word presented without a pop; 0 = standard, data one cycle after pop
- AFULL_LVL, DEPTH-4, o_afull threshold; legal range 1..DEPTH
- AEMPTY_LVL, 4, o_aempty threshold; legal range 0..DEPTH-1

Ports:
- i_clk  in  1  sole clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_flush  in  1  synchronous flush; empties FIFO, clears error flags
- i_push  in  1  write request
- i_wdata  in  DATA_WIDTH  write data, sampled on accepted push
- i_pop  in  1  read request
- o_rdata  out  DATA_WIDTH  read data
- o_rvalid  out  1  o_rdata valid
- o_full  out  1  level == DEPTH
- o_empty  out  1  level == 0
- o_afull  out  1  level >= AFULL_LVL
- o_aempty  out  1  level <= AEMPTY_LVL
- o_level  out  PTR_WIDTH+1  words stored, 0..DEPTH
- o_ovf  out  1  sticky: push attempted while full
- o_udf  out  1  sticky: pop attempted while empty

## Operation
- Pointers are PTR_WIDTH+1 bits; the MSB is the wrap bit. Addresses wrap DEPTH-1 -> 0 with no gap.
- Accepted push = i_push & ~o_full & ~i_flush. Accepted pop = i_pop & ~o_empty & ~i_flush.
- A push while full is dropped and sets o_ovf. A push is rejected when full even if a pop occurs in the same cycle.
- A pop while empty is ignored and sets o_udf.
- Push and pop in the same cycle with 0 < level < DEPTH: both are accepted and the level is unchanged.
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
- All flags decode from the level register. The flags are mutually consistent in every cycle.
- FWFT=1:
  - o_rvalid = ~o_empty.
  - o_rdata equals the oldest stored word whenever o_rvalid is high.
  - After an accepted pop, the next word (or o_rvalid low) is presented the following cycle.
- FWFT=0:
  - An accepted pop in cycle N drives o_rdata with the popped word and pulses o_rvalid high in cycle N+1.
  - o_rdata holds its value otherwise.
- Flush (i_flush=1 in cycle N):
  - From N+1: pointers = 0, level = 0, o_ovf = 0, o_udf = 0, o_rvalid = 0.
  - Flush overrides push and pop in cycle N, which are neither accepted nor flagged.
  - Storage contents are not cleared.
- o_ovf and o_udf clear only on reset or flush.

## Timing
- Reset values: o_level 0, o_empty 1, o_full 0, o_aempty 1, o_afull 0, o_rvalid 0, o_rdata 0, o_ovf 0, o_udf 0. Pointers are 0.
- Reset asserted mid-operation discards all content immediately (asynchronously). Deassertion is synchronised externally.
- Push in cycle N:
  - o_level, o_full, o_afull, o_empty and o_aempty update in N+1.
  - In FWFT mode, a push into an empty FIFO gives o_rvalid=1 with that word in N+1.
- Pop in cycle N: the flags update in N+1.
- Read latency: FWFT 0 cycles from head availability; standard mode 1 cycle after pop.
- o_ovf and o_udf set in the cycle after the offending request.
- Sustained throughput is one push and one pop per cycle. No combinational path from i_push or i_pop to any output.

## Test plan
Bench configuration: PTR_WIDTH=3 (DEPTH 8), AFULL_LVL=6, AEMPTY_LVL=2, unless stated.
- Fill and drain, FWFT=1: push 0x01..0x08 back-to-back.
  - Required: o_level steps 1..8; o_aempty drops when level = 3; o_afull rises when level = 6; o_full = 1 at 8.
  - Then pop 8 times. Required: o_rdata = 0x01..0x08 in order; o_empty = 1 after the last pop.
- Overflow: when full, push 0xAA.
  - Required: o_ovf = 1 next cycle; o_level stays 8; later pops never return 0xAA.
  - Simultaneous push and pop while full: the pop is accepted, the push is dropped, o_ovf sets, and o_level becomes 7.
- Underflow and wrap: pop while empty.
  - Required: o_udf = 1; o_level stays 0.
  - Then run 20 cycles of simultaneous push/pop at level 3. Required: o_level stays 3 and data order is preserved across pointer wrap.
- Standard mode (FWFT=0): push 0x5A, then pop in cycle N.
  - Required: o_rvalid = 1 and o_rdata = 0x5A in N+1 only; o_rvalid = 0 in N+2.
- Flush: at level 5 with o_ovf = 1, assert i_flush together with i_push.
  - Required next cycle: o_level 0, o_empty 1, o_ovf 0, o_rvalid 0. The next push of 0x33 is read back as 0x33.
- Async reset mid-stream: at level 4, pulse i_rst_n low between clock edges.
  - Required: all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/tx_sync_fifo.sv
// Single-clock transmit FIFO with inferred storage, selectable first-word-fall-through
// or standard read mode, level/threshold flags, sticky overflow/underflow and sync flush.
module tx_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 11,
    parameter int unsigned FWFT       = 1,
    parameter int unsigned AFULL_LVL  = (2 ** PTR_WIDTH) - 4,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic [PTR_WIDTH:0]    o_level,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int unsigned DEPTH = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_L  = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AFULL_L  = (PTR_WIDTH + 1)'(AFULL_LVL);
    localparam logic [PTR_WIDTH:0] AEMPTY_L = (PTR_WIDTH + 1)'(AEMPTY_LVL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0] level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               push_ok;
    logic               pop_ok;
    logic [DATA_WIDTH-1:0] head;

    // Flags decode from the level register only, so they are glitch-free and consistent.
    always_comb begin
        o_level  = level_q;
        o_full   = (level_q == DEPTH_L);
        o_empty  = (level_q == '0);
        o_afull  = (level_q >= AFULL_L);
        o_aempty = (level_q <= AEMPTY_L);
        o_ovf    = ovf_q;
        o_udf    = udf_q;
    end

    // Request qualification; flush suppresses both acceptance and error flagging.
    always_comb begin
        push_ok = i_push & ~o_full & ~i_flush;
        pop_ok  = i_pop & ~o_empty & ~i_flush;
    end

    // Next-state for pointers, level and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            // A push while full is rejected even if a pop frees a slot this cycle.
            if (i_push & o_full) begin
                ovf_d = 1'b1;
            end
            if (i_pop & o_empty) begin
                udf_d = 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write; the array has no reset so it maps onto RAM.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[PTR_WIDTH-1:0]] <= i_wdata;
        end
    end

    // Oldest stored word.
    always_comb begin
        head = mem[rd_ptr_q[PTR_WIDTH-1:0]];
    end

    if (FWFT != 0) begin : g_fwft
        // Head presented directly; forced to zero while empty so stale RAM never leaks out.
        always_comb begin
            o_rvalid = ~o_empty;
            o_rdata  = o_empty ? '0 : head;
        end
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;

        // Registered read port: popped word appears with a one-cycle valid pulse.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= pop_ok;
                if (pop_ok) begin
                    rdata_q <= head;
                end
            end
        end

        // Drive the read outputs from the registered port.
        always_comb begin
            o_rvalid = rvalid_q;
            o_rdata  = rdata_q;
        end
    end

endmodule
